// File: rtl/proj_fm_ring_pkg.sv
// proj_fm_ring_pkg: shared constants and index type for the fragment-memory ring.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proj_fm_ring_pkg;

  localparam int FM_RING_BUFFER_COUNT      = 4;
  localparam int FM_RING_BUFFER_WORDS      = 16;
  localparam int FM_RING_DATA_BITS         = 2;
  localparam int FM_RING_FRAG_LEN          = 8;
  localparam int FM_RING_READ_PORTS        = 2;
  localparam int FM_RING_SIGNED_INDICE_LEN = 8;

  // Signed symbol index, relative to the first symbol of the newest committed buffer.
  typedef logic signed [FM_RING_SIGNED_INDICE_LEN-1:0] fm_ring_idx_t;

endpackage

// File: rtl/proj_fm_ring_rd.sv
// proj_fm_ring_rd: one read channel; range-checks a signed index, assembles a fragment that may straddle buffers.
// Latency: 1 cycle, response registered and held for exactly one cycle.
// Backpressure: none; a request is accepted every cycle, out-of-range requests answer with rsp_oob and zero data.
// Ports: in_clk/in_rst clock and sync reset; req_vld/req_idx request; mem_dat flat ring storage;
//   active_buf/hist newest committed buffer and readable history count; rsp_vld/rsp_oob/rsp_dat response.
module proj_fm_ring_rd
  import proj_fm_ring_pkg::*;
#(
  parameter int BUFFER_COUNT      = FM_RING_BUFFER_COUNT,
  parameter int BUFFER_WORDS      = FM_RING_BUFFER_WORDS,
  parameter int DATA_BITS         = FM_RING_DATA_BITS,
  parameter int FRAG_LEN          = FM_RING_FRAG_LEN,
  parameter int SIGNED_INDICE_LEN = FM_RING_SIGNED_INDICE_LEN
) (
  input  logic                                             in_clk,
  input  logic                                             in_rst,
  input  logic                                             req_vld,
  input  logic signed [SIGNED_INDICE_LEN-1:0]              req_idx,
  input  logic [BUFFER_COUNT*BUFFER_WORDS*DATA_BITS-1:0]   mem_dat,
  input  logic [$clog2(BUFFER_COUNT)-1:0]                  active_buf,
  input  logic [$clog2(BUFFER_COUNT)-1:0]                  hist,
  output logic                                             rsp_vld,
  output logic                                             rsp_oob,
  output logic [FRAG_LEN-1:0]                              rsp_dat
);

  localparam int FRAG_SYMS = FRAG_LEN / DATA_BITS;
  localparam int WORD_SH   = $clog2(BUFFER_WORDS);
  localparam int MEM_BITS  = BUFFER_COUNT * BUFFER_WORDS * DATA_BITS;
  localparam int MA_W      = $clog2(MEM_BITS);

  int                  idx_s;
  int                  lo_lim;
  logic                in_range;
  logic [FRAG_LEN-1:0] frag;

  // Oldest readable symbol sits (hist-1) whole buffers behind the newest one.
  always_comb begin
    idx_s    = int'(req_idx);
    lo_lim   = -(int'(hist) - 1) * BUFFER_WORDS;
    in_range = (hist != '0) && (idx_s >= lo_lim) && (idx_s <= BUFFER_WORDS - FRAG_SYMS);
  end

  // Each symbol is located independently, so a fragment crossing a buffer boundary
  // simply picks its symbols from two buffers. An arithmetic shift of the position
  // gives floor(pos/BUFFER_WORDS), i.e. minus the number of buffers to step back.
  // Out-of-range requests are steered to position 0 so every select stays in bounds.
  always_comb begin
    int pos;
    int back;
    int off;
    int bufn;
    frag = '0;
    pos  = 0;
    back = 0;
    off  = 0;
    bufn = 0;
    for (int j = 0; j < FRAG_SYMS; j++) begin
      pos  = in_range ? idx_s + j : 0;
      back = pos >>> WORD_SH;
      off  = pos & (BUFFER_WORDS - 1);
      bufn = (int'(active_buf) + BUFFER_COUNT + back) % BUFFER_COUNT;
      frag[j*DATA_BITS +: DATA_BITS] =
        mem_dat[MA_W'((bufn * BUFFER_WORDS + off) * DATA_BITS) +: DATA_BITS];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rsp_vld <= 1'b0;
      rsp_oob <= 1'b0;
      rsp_dat <= '0;
    end else begin
      rsp_vld <= req_vld;
      rsp_oob <= req_vld && !in_range;
      rsp_dat <= (req_vld && in_range) ? frag : '0;
    end
  end

endmodule

// File: rtl/proj_fm_ring.sv
// proj_fm_ring: ring of BUFFER_COUNT symbol buffers; one fills from the write stream, up to BUFFER_COUNT-1 serve reads.
// Latency: read response and chg_idx rejection both appear 1 cycle after the request.
// Backpressure: out_wready drops while the write buffer is full; offered symbols are then dropped until a commit.
// Ports: in_clk/in_rst clock and sync reset; in_wvalid/in_wdata/out_wready write stream; chg_idx/out_chg_err commit;
//   out_wr_count/out_hist status; in_rd_valid/frag_idx per-port requests; out_rd_valid/out_rd_oob/out_rdata responses.
module proj_fm_ring
  import proj_fm_ring_pkg::*;
#(
  parameter int BUFFER_COUNT      = FM_RING_BUFFER_COUNT,
  parameter int BUFFER_WORDS      = FM_RING_BUFFER_WORDS,
  parameter int DATA_BITS         = FM_RING_DATA_BITS,
  parameter int FRAG_LEN          = FM_RING_FRAG_LEN,
  parameter int READ_PORTS        = FM_RING_READ_PORTS,
  parameter int SIGNED_INDICE_LEN = FM_RING_SIGNED_INDICE_LEN
) (
  input  logic                                  in_clk,
  input  logic                                  in_rst,
  input  logic                                  in_wvalid,
  input  logic [DATA_BITS-1:0]                  in_wdata,
  output logic                                  out_wready,
  input  logic                                  chg_idx,
  output logic                                  out_chg_err,
  output logic [$clog2(BUFFER_WORDS+1)-1:0]     out_wr_count,
  output logic [$clog2(BUFFER_COUNT)-1:0]       out_hist,
  input  logic [READ_PORTS-1:0]                 in_rd_valid,
  input  logic [READ_PORTS*SIGNED_INDICE_LEN-1:0] frag_idx,
  output logic [READ_PORTS-1:0]                 out_rd_valid,
  output logic [READ_PORTS-1:0]                 out_rd_oob,
  output logic [READ_PORTS*FRAG_LEN-1:0]        out_rdata
);

  localparam int BUF_W    = $clog2(BUFFER_COUNT);
  localparam int CNT_W    = $clog2(BUFFER_WORDS + 1);
  localparam int MEM_BITS = BUFFER_COUNT * BUFFER_WORDS * DATA_BITS;
  localparam int MA_W     = $clog2(MEM_BITS);

  // Storage is never reset; out_hist alone decides which buffers are visible.
  logic [MEM_BITS-1:0] mem;

  logic [BUF_W-1:0] wr_buf;
  logic [BUF_W-1:0] wr_buf_nxt;
  logic [BUF_W-1:0] active_buf;
  logic [CNT_W-1:0] wr_count;
  logic [CNT_W-1:0] wr_count_nxt;
  logic [BUF_W-1:0] hist;
  logic [BUF_W-1:0] hist_nxt;
  logic             chg_err_nxt;
  logic             wr_fire;
  logic             commit;
  logic [MA_W-1:0]  wr_bit;

  assign out_wready   = (wr_count < CNT_W'(BUFFER_WORDS));
  assign wr_fire      = in_wvalid && out_wready;
  assign commit       = chg_idx && (wr_count == CNT_W'(BUFFER_WORDS));
  assign out_wr_count = wr_count;
  assign out_hist     = hist;

  // The newest committed buffer is always the one just behind the write buffer.
  assign active_buf = (wr_buf == '0) ? BUF_W'(BUFFER_COUNT - 1) : wr_buf - 1'b1;

  // commit needs a full buffer and wr_fire needs a non-full one, so they never coincide.
  always_comb begin
    wr_count_nxt = wr_count;
    wr_buf_nxt   = wr_buf;
    hist_nxt     = hist;
    chg_err_nxt  = 1'b0;
    if (commit) begin
      wr_count_nxt = '0;
      wr_buf_nxt   = (wr_buf == BUF_W'(BUFFER_COUNT - 1)) ? '0 : wr_buf + 1'b1;
      if (hist != BUF_W'(BUFFER_COUNT - 1)) begin
        hist_nxt = hist + 1'b1;
      end
    end else begin
      if (wr_fire) begin
        wr_count_nxt = wr_count + 1'b1;
      end
      if (chg_idx) begin
        chg_err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wr_count    <= '0;
      wr_buf      <= '0;
      hist        <= '0;
      out_chg_err <= 1'b0;
    end else begin
      wr_count    <= wr_count_nxt;
      wr_buf      <= wr_buf_nxt;
      hist        <= hist_nxt;
      out_chg_err <= chg_err_nxt;
    end
  end

  assign wr_bit = MA_W'((int'(wr_buf) * BUFFER_WORDS + int'(wr_count)) * DATA_BITS);

  always_ff @(posedge in_clk) begin
    if (!in_rst && wr_fire) begin
      mem[wr_bit +: DATA_BITS] <= in_wdata;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    proj_fm_ring_rd #(
      .BUFFER_COUNT      (BUFFER_COUNT),
      .BUFFER_WORDS      (BUFFER_WORDS),
      .DATA_BITS         (DATA_BITS),
      .FRAG_LEN          (FRAG_LEN),
      .SIGNED_INDICE_LEN (SIGNED_INDICE_LEN)
    ) u_rd (
      .in_clk     (in_clk),
      .in_rst     (in_rst),
      .req_vld    (in_rd_valid[p]),
      .req_idx    (frag_idx[p*SIGNED_INDICE_LEN +: SIGNED_INDICE_LEN]),
      .mem_dat    (mem),
      .active_buf (active_buf),
      .hist       (hist),
      .rsp_vld    (out_rd_valid[p]),
      .rsp_oob    (out_rd_oob[p]),
      .rsp_dat    (out_rdata[p*FRAG_LEN +: FRAG_LEN])
    );
  end

endmodule

// File: tb/tb_proj_fm_ring.sv
// tb_proj_fm_ring: directed scenarios plus randomized back-to-back traffic against a queue-based history model.
// Latency: checks responses one cycle after each request.
// Backpressure: the model drops writes offered while its write buffer holds BUFFER_WORDS symbols.
module tb_proj_fm_ring;
  import proj_fm_ring_pkg::*;

  localparam int BC  = 4;
  localparam int BW  = 16;
  localparam int DB  = 2;
  localparam int FL  = 8;
  localparam int RP  = 2;
  localparam int SIL = 8;
  localparam int FS  = FL / DB;

  logic                     in_clk = 1'b0;
  logic                     in_rst = 1'b1;
  logic                     in_wvalid = 1'b0;
  logic [DB-1:0]            in_wdata = '0;
  logic                     out_wready;
  logic                     chg_idx = 1'b0;
  logic                     out_chg_err;
  logic [$clog2(BW+1)-1:0]  out_wr_count;
  logic [$clog2(BC)-1:0]    out_hist;
  logic [RP-1:0]            in_rd_valid = '0;
  logic [RP*SIL-1:0]        frag_idx = '0;
  logic [RP-1:0]            out_rd_valid;
  logic [RP-1:0]            out_rd_oob;
  logic [RP*FL-1:0]         out_rdata;

  always #5 in_clk = ~in_clk;

  proj_fm_ring #(
    .BUFFER_COUNT(BC), .BUFFER_WORDS(BW), .DATA_BITS(DB),
    .FRAG_LEN(FL), .READ_PORTS(RP), .SIGNED_INDICE_LEN(SIL)
  ) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_wvalid(in_wvalid), .in_wdata(in_wdata),
    .out_wready(out_wready), .chg_idx(chg_idx), .out_chg_err(out_chg_err),
    .out_wr_count(out_wr_count), .out_hist(out_hist), .in_rd_valid(in_rd_valid),
    .frag_idx(frag_idx), .out_rd_valid(out_rd_valid), .out_rd_oob(out_rd_oob),
    .out_rdata(out_rdata)
  );

  typedef logic [DB-1:0] sym_t;
  typedef sym_t buf_t [BW];

  // Reference model: the symbols of the open buffer, and the readable committed buffers oldest first.
  sym_t wq[$];
  buf_t hq[$];

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  function automatic void model_reset();
    wq.delete();
    hq.delete();
  endfunction

  function automatic void model_commit();
    buf_t b;
    for (int j = 0; j < BW; j++) b[j] = wq[j];
    hq.push_back(b);
    if (hq.size() > BC - 1) hq.delete(0);
    wq.delete();
  endfunction

  // History viewed as one long symbol string; idx 0 is the start of the newest buffer.
  function automatic void model_read(input int idx, output logic oob, output logic [FL-1:0] d);
    int h;
    int pos;
    int s;
    h = hq.size();
    d = '0;
    oob = 1'b1;
    if (h == 0) return;
    pos = (h - 1) * BW + idx;
    if (pos < 0 || idx > BW - FS) return;
    oob = 1'b0;
    for (int j = 0; j < FS; j++) begin
      s = pos + j;
      d[j*DB +: DB] = hq[s / BW][s % BW];
    end
  endfunction

  task automatic write_sym(input sym_t d);
    logic acc;
    acc = (wq.size() < BW);
    in_wvalid = 1'b1;
    in_wdata  = d;
    tick();
    in_wvalid = 1'b0;
    if (acc) wq.push_back(d);
  endtask

  task automatic commit_pulse();
    logic ok;
    ok = (wq.size() == BW);
    chg_idx = 1'b1;
    tick();
    chg_idx = 1'b0;
    if (ok) model_commit();
  endtask

  task automatic do_read(input int port, input int idx, output logic v, output logic oob,
                         output logic [FL-1:0] d);
    in_rd_valid = '0;
    in_rd_valid[port] = 1'b1;
    frag_idx[port*SIL +: SIL] = SIL'(idx);
    tick();
    in_rd_valid = '0;
    v   = out_rd_valid[port];
    oob = out_rd_oob[port];
    d   = out_rdata[port*FL +: FL];
  endtask

  task automatic test_reset();
    logic v, oob;
    logic [FL-1:0] d;
    in_rst = 1'b1;
    tick();
    tick();
    in_rst = 1'b0;
    model_reset();
    checks++;
    if ({out_wready, out_wr_count, out_hist, out_chg_err, out_rd_valid, out_rd_oob, out_rdata}
        !== {1'b1, 5'd0, 2'd0, 1'b0, 2'b00, 2'b00, 16'h0}) begin
      errors++;
      $display("FAIL reset_state: wready=%0b wr_count=%0d hist=%0d err=%0b rv=%b oob=%b rdata=%h required 1 0 0 0 00 00 0000",
               out_wready, out_wr_count, out_hist, out_chg_err, out_rd_valid, out_rd_oob, out_rdata);
    end
    do_read(0, 0, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL reset_read: v=%0b oob=%0b d=%h required 1 1 00", v, oob, d);
    end
    tick();
    checks++;
    if (out_rd_valid !== 2'b00) begin
      errors++;
      $display("FAIL rd_valid_idle: got %b required 00", out_rd_valid);
    end
  endtask

  task automatic test_fill_commit();
    logic v, oob;
    logic [FL-1:0] d;
    for (int i = 0; i < BW; i++) write_sym(sym_t'(i & 3));
    checks++;
    if ({out_wready, out_wr_count} !== {1'b0, 5'd16}) begin
      errors++;
      $display("FAIL full_state: wready=%0b wr_count=%0d required 0 16", out_wready, out_wr_count);
    end
    write_sym(2'd2);
    checks++;
    if (out_wr_count !== 5'd16) begin
      errors++;
      $display("FAIL drop_17th: wr_count=%0d required 16", out_wr_count);
    end
    commit_pulse();
    checks++;
    if ({out_chg_err, out_hist, out_wr_count, out_wready} !== {1'b0, 2'd1, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL commit_a: err=%0b hist=%0d wr_count=%0d wready=%0b required 0 1 0 1",
               out_chg_err, out_hist, out_wr_count, out_wready);
    end
    do_read(0, 0, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b0, 8'hE4}) begin
      errors++;
      $display("FAIL read_a_0: v=%0b oob=%0b d=%h required 1 0 e4", v, oob, d);
    end
    do_read(1, 12, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b0, 8'hE4}) begin
      errors++;
      $display("FAIL read_a_12: v=%0b oob=%0b d=%h required 1 0 e4", v, oob, d);
    end
    do_read(0, 13, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL read_a_13: v=%0b oob=%0b d=%h required 1 1 00", v, oob, d);
    end
  endtask

  task automatic test_straddle();
    logic v, oob;
    logic [FL-1:0] d;
    for (int i = 0; i < BW; i++) write_sym(sym_t'(3 - (i & 3)));
    commit_pulse();
    checks++;
    if (out_hist !== 2'd2) begin
      errors++;
      $display("FAIL commit_b_hist: got %0d required 2", out_hist);
    end
    do_read(0, -2, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b0, 8'hBE}) begin
      errors++;
      $display("FAIL straddle_m2: v=%0b oob=%0b d=%h required 1 0 be", v, oob, d);
    end
    do_read(1, -16, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b0, 8'hE4}) begin
      errors++;
      $display("FAIL read_m16: v=%0b oob=%0b d=%h required 1 0 e4", v, oob, d);
    end
    do_read(0, -17, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL read_m17: v=%0b oob=%0b d=%h required 1 1 00", v, oob, d);
    end
  endtask

  task automatic test_chg_err();
    for (int i = 0; i < 5; i++) write_sym(sym_t'($urandom_range(0, 3)));
    commit_pulse();
    checks++;
    if (out_chg_err !== 1'b1) begin
      errors++;
      $display("FAIL chg_err_pulse: got %0b required 1", out_chg_err);
    end
    tick();
    checks++;
    if ({out_chg_err, out_hist, out_wr_count} !== {1'b0, 2'd2, 5'd5}) begin
      errors++;
      $display("FAIL chg_err_after: err=%0b hist=%0d wr_count=%0d required 0 2 5",
               out_chg_err, out_hist, out_wr_count);
    end
    in_wvalid = 1'b1;
    in_wdata  = sym_t'($urandom_range(0, 3));
    chg_idx   = 1'b1;
    tick();
    in_wvalid = 1'b0;
    chg_idx   = 1'b0;
    wq.push_back(in_wdata);
    checks++;
    if ({out_chg_err, out_wr_count} !== {1'b1, 5'd6}) begin
      errors++;
      $display("FAIL chg_err_with_write: err=%0b wr_count=%0d required 1 6", out_chg_err, out_wr_count);
    end
  endtask

  task automatic test_wrap_saturate();
    logic v, oob, eoob;
    logic [FL-1:0] d, ed;
    logic [FL-1:0] d1;
    int ncommit;
    ncommit = 2;
    for (int b = 0; b < 3; b++) begin
      while (wq.size() < BW) write_sym(sym_t'($urandom_range(0, 3)));
      commit_pulse();
      ncommit++;
      checks++;
      if (out_hist !== 2'((ncommit < BC - 1) ? ncommit : BC - 1)) begin
        errors++;
        $display("FAIL hist_saturate_%0d: got %0d required %0d", ncommit, out_hist,
                 (ncommit < BC - 1) ? ncommit : BC - 1);
      end
    end
    do_read(0, -32, v, oob, d);
    model_read(-32, eoob, ed);
    checks++;
    if ({v, oob, d} !== {1'b1, eoob, ed}) begin
      errors++;
      $display("FAIL read_m32: v=%0b oob=%0b d=%h required 1 %0b %h", v, oob, d, eoob, ed);
    end
    do_read(1, -33, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL read_m33: v=%0b oob=%0b d=%h required 1 1 00", v, oob, d);
    end
    in_rd_valid = 2'b11;
    frag_idx    = {8'hFE, 8'h00};
    tick();
    in_rd_valid = '0;
    model_read(0, eoob, ed);
    checks++;
    if ({out_rd_valid[0], out_rd_oob[0], out_rdata[7:0]} !== {1'b1, eoob, ed}) begin
      errors++;
      $display("FAIL dual_port0: v=%0b oob=%0b d=%h required 1 %0b %h",
               out_rd_valid[0], out_rd_oob[0], out_rdata[7:0], eoob, ed);
    end
    model_read(-2, eoob, d1);
    checks++;
    if ({out_rd_valid[1], out_rd_oob[1], out_rdata[15:8]} !== {1'b1, eoob, d1}) begin
      errors++;
      $display("FAIL dual_port1: v=%0b oob=%0b d=%h required 1 %0b %h",
               out_rd_valid[1], out_rd_oob[1], out_rdata[15:8], eoob, d1);
    end
  endtask

  task automatic test_reset_midfill();
    logic v, oob;
    logic [FL-1:0] d;
    for (int i = 0; i < 7; i++) write_sym(sym_t'($urandom_range(0, 3)));
    checks++;
    if (out_wr_count !== 5'd7) begin
      errors++;
      $display("FAIL midfill_count: got %0d required 7", out_wr_count);
    end
    in_rst      = 1'b1;
    in_rd_valid = 2'b01;
    frag_idx    = '0;
    tick();
    in_rst      = 1'b0;
    in_rd_valid = '0;
    model_reset();
    checks++;
    if ({out_rd_valid, out_wr_count, out_hist, out_wready} !== {2'b00, 5'd0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL midfill_reset: rv=%b wr_count=%0d hist=%0d wready=%0b required 00 0 0 1",
               out_rd_valid, out_wr_count, out_hist, out_wready);
    end
    do_read(0, 0, v, oob, d);
    checks++;
    if ({v, oob, d} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL midfill_read: v=%0b oob=%0b d=%h required 1 1 00", v, oob, d);
    end
  endtask

  // Every cycle carries random writes, commit attempts and reads on both ports.
  task automatic test_back_to_back();
    logic             rv  [RP];
    logic             eo  [RP];
    logic [FL-1:0]    ed  [RP];
    int               idx [RP];
    logic             wv, cv, exp_err, do_commit, do_write;
    sym_t             wd;
    for (int cyc = 0; cyc < 600; cyc++) begin
      wv = ($urandom_range(0, 3) != 0);
      wd = sym_t'($urandom_range(0, 3));
      cv = ($urandom_range(0, 5) == 0);
      for (int p = 0; p < RP; p++) begin
        rv[p]  = ($urandom_range(0, 3) != 0);
        idx[p] = int'($urandom_range(0, 80)) - 64;
        model_read(idx[p], eo[p], ed[p]);
        in_rd_valid[p] = rv[p];
        frag_idx[p*SIL +: SIL] = SIL'(idx[p]);
      end
      do_commit = cv && (wq.size() == BW);
      exp_err   = cv && !do_commit;
      do_write  = wv && (wq.size() < BW);
      in_wvalid = wv;
      in_wdata  = wd;
      chg_idx   = cv;
      tick();
      for (int p = 0; p < RP; p++) begin
        checks++;
        if ({out_rd_valid[p], out_rd_oob[p], out_rdata[p*FL +: FL]}
            !== {rv[p], rv[p] & eo[p], rv[p] ? ed[p] : 8'h00}) begin
          errors++;
          $display("FAIL rand_read c%0d p%0d idx %0d: v=%0b oob=%0b d=%h required %0b %0b %h",
                   cyc, p, idx[p], out_rd_valid[p], out_rd_oob[p], out_rdata[p*FL +: FL],
                   rv[p], rv[p] & eo[p], rv[p] ? ed[p] : 8'h00);
        end
      end
      if (do_write) wq.push_back(wd);
      if (do_commit) model_commit();
      checks++;
      if ({out_chg_err, out_wr_count, out_hist} !== {exp_err, 5'(wq.size()), 2'(hq.size())}) begin
        errors++;
        $display("FAIL rand_state c%0d: err=%0b wr_count=%0d hist=%0d required %0b %0d %0d",
                 cyc, out_chg_err, out_wr_count, out_hist, exp_err, wq.size(), hq.size());
      end
    end
    in_wvalid   = 1'b0;
    chg_idx     = 1'b0;
    in_rd_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fill_commit();
    test_straddle();
    test_chg_err();
    test_wrap_saturate();
    test_reset_midfill();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
